// File: rtl/ann_image_sequencer_if.sv
// ---------------------------------------------------------------------------
// ann_image_sequencer_if
// Bundles the two handshakes of the image sequencer:
//   - ANN request side : start_detecting / image_address out, done_processing /
//                        seven_seg back from the ANN core.
//   - result side      : result_valid / result_data / result_index out,
//                        result_ready back from the downstream consumer.
// master : the sequencer (drives requests and results).
// slave  : the environment (ANN core plus result consumer).
// ---------------------------------------------------------------------------
interface ann_image_sequencer_if #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 6
);
   logic              start_detecting;
   logic [ADDR_W-1:0] image_address;
   logic              done_processing;
   logic [7:0]        seven_seg;
   logic              result_valid;
   logic              result_ready;
   logic [7:0]        result_data;
   logic [CNT_W-1:0]  result_index;

   modport master (
      output start_detecting, image_address, result_valid, result_data, result_index,
      input  done_processing, seven_seg, result_ready
   );

   modport slave (
      input  start_detecting, image_address, result_valid, result_data, result_index,
      output done_processing, seven_seg, result_ready
   );
endinterface

// File: rtl/ann_image_sequencer.sv
// ---------------------------------------------------------------------------
// ann_image_sequencer
// Walks a batch of images stored back-to-back in image SRAM, issues one
// detection request per image to the ANN core, waits (bounded) for its
// completion pulse and hands each result downstream over valid/ready.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a batch (only honoured while idle)
//   base_address      : SRAM address of image 0, latched on accepted start
//   num_images        : images in the batch, latched on accepted start
//   bus (master)      : ANN request/response and result handshake signals
//   busy              : high from accepted start until the finish cycle ends
//   batch_done        : one-cycle pulse at end of batch (normal or aborted)
//   timeout_err       : sticky; set when the ANN fails to respond in time
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module ann_image_sequencer #(
   parameter int IMAGE_SIZE     = 64,
   parameter int ADDR_W         = 10,
   parameter int CNT_W          = 6,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_address,
   input  logic [CNT_W-1:0]     num_images,
   ann_image_sequencer_if.master bus,
   output logic                 busy,
   output logic                 batch_done,
   output logic                 timeout_err
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_HOLD   = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] base_r, base_s;
   logic [CNT_W-1:0]  num_r, num_s;
   logic [CNT_W-1:0]  index_r, index_s;
   logic [TW-1:0]     tcnt_r, tcnt_s;
   logic              req_r, req_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic              valid_r, valid_s;
   logic [7:0]        data_r, data_s;
   logic [CNT_W-1:0]  ridx_r, ridx_s;
   logic              busy_r, busy_s;
   logic              bdone_r, bdone_s;
   logic              terr_r, terr_s;

   // Image address = base + idx*IMAGE_SIZE, silently wrapping to ADDR_W bits.
   function automatic logic [ADDR_W-1:0] addr_calc(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
      logic [31:0] sum;
      sum = 32'(base) + (32'(idx) * 32'(IMAGE_SIZE));
      return sum[ADDR_W-1:0];
   endfunction

   // Next-state and next-output logic; register outputs are computed one cycle
   // ahead so that e.g. start_detecting is high exactly while in ISSUE.
   always_comb begin
      state_s = state_r;
      base_s  = base_r;
      num_s   = num_r;
      index_s = index_r;
      tcnt_s  = tcnt_r;
      req_s   = 1'b0;
      addr_s  = addr_r;
      valid_s = valid_r;
      data_s  = data_r;
      ridx_s  = ridx_r;
      busy_s  = busy_r;
      bdone_s = 1'b0;
      terr_s  = terr_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               base_s  = base_address;
               num_s   = num_images;
               index_s = {CNT_W{1'b0}};
               terr_s  = 1'b0;
               busy_s  = 1'b1;
               if (num_images == {CNT_W{1'b0}}) begin
                  state_s = S_FINISH;
                  bdone_s = 1'b1;
               end else begin
                  state_s = S_ISSUE;
                  req_s   = 1'b1;
                  addr_s  = addr_calc(base_address, {CNT_W{1'b0}});
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ISSUE: begin
            // done_processing is deliberately not looked at here
            tcnt_s  = {TW{1'b0}};
            state_s = S_WAIT;
         end
         S_WAIT: begin
            // done has priority over a timeout falling in the same cycle
            if (bus.done_processing) begin
               data_s  = bus.seven_seg;
               ridx_s  = index_r;
               valid_s = 1'b1;
               state_s = S_HOLD;
            end else if (tcnt_r == T_LAST) begin
               terr_s  = 1'b1;
               bdone_s = 1'b1;
               state_s = S_FINISH;
            end else begin
               tcnt_s  = tcnt_r + TW'(1);
            end
         end
         S_HOLD: begin
            if (valid_r && bus.result_ready) begin
               valid_s = 1'b0;
               index_s = index_r + CNT_W'(1);
               if (index_r == (num_r - CNT_W'(1))) begin
                  bdone_s = 1'b1;
                  state_s = S_FINISH;
               end else begin
                  req_s   = 1'b1;
                  addr_s  = addr_calc(base_r, index_r + CNT_W'(1));
                  state_s = S_ISSUE;
               end
            end else begin
               state_s = S_HOLD;
            end
         end
         S_FINISH: begin
            busy_s  = 1'b0;
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
            valid_s = 1'b0;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
         base_r  <= {ADDR_W{1'b0}};
         num_r   <= {CNT_W{1'b0}};
         index_r <= {CNT_W{1'b0}};
         tcnt_r  <= {TW{1'b0}};
         req_r   <= 1'b0;
         addr_r  <= {ADDR_W{1'b0}};
         valid_r <= 1'b0;
         data_r  <= 8'h00;
         ridx_r  <= {CNT_W{1'b0}};
         busy_r  <= 1'b0;
         bdone_r <= 1'b0;
         terr_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         base_r  <= base_s;
         num_r   <= num_s;
         index_r <= index_s;
         tcnt_r  <= tcnt_s;
         req_r   <= req_s;
         addr_r  <= addr_s;
         valid_r <= valid_s;
         data_r  <= data_s;
         ridx_r  <= ridx_s;
         busy_r  <= busy_s;
         bdone_r <= bdone_s;
         terr_r  <= terr_s;
      end
   end

   assign bus.start_detecting = req_r;
   assign bus.image_address   = addr_r;
   assign bus.result_valid    = valid_r;
   assign bus.result_data     = data_r;
   assign bus.result_index    = ridx_r;
   assign busy                = busy_r;
   assign batch_done          = bdone_r;
   assign timeout_err         = terr_r;

endmodule
